// File: rtl/fr_normalizer.sv
// fr_normalizer: post-add normalizer for the FP MAC (exponent delay line, carry fix-up, LZC, shift/pack).
// Define FR_NORM_RNE_EN to round to nearest-even in the last stage; without it the result is truncated.
module fr_normalizer #(
  parameter int ADDER_LAT = 8,
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 24
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   valid_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W-1:0]       sum_in,
  input  logic                   sign_in,
  input  logic                   carry_in,
  output logic [EXP_W+MAN_W-1:0] result_out,
  output logic                   valid_out,
  output logic                   zero_out,
  output logic                   ovf_out,
  output logic                   unf_out
);
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(MAN_W + 1);
  localparam int RW  = EXP_W + MAN_W;

  typedef logic signed [XW-1:0] sexp_t;
  localparam sexp_t EXP_MAX = sexp_t'((1 << EXP_W) - 1);

  // Exponent delay line, aligned with the adder pipeline.
  logic [ADDER_LAT-1:0] dly_valid_q, dly_valid_d;
  logic [EXP_W-1:0]     dly_exp_q [ADDER_LAT];
  logic [EXP_W-1:0]     dly_exp_d [ADDER_LAT];

  always_comb begin
    dly_valid_d[0] = valid_in;
    dly_exp_d[0]   = exp_in;
    for (int i = 1; i < ADDER_LAT; i++) begin
      dly_valid_d[i] = dly_valid_q[i-1];
      dly_exp_d[i]   = dly_exp_q[i-1];
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
  // NOTE: the delay line is reset entry by entry, not left as memory, since a stale valid bit would emit a phantom result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dly_valid_q <= '0;
      for (int i = 0; i < ADDER_LAT; i++) dly_exp_q[i] <= '0;
    end else begin
      dly_valid_q <= dly_valid_d;
      dly_exp_q   <= dly_exp_d;
    end
  end

  // N1: carry fix-up.
  logic             n1_valid_q, n1_valid_d;
  logic             n1_sign_q, n1_sign_d;
  logic [MAN_W-1:0] n1_mant_q, n1_mant_d;
  sexp_t            n1_exp_q, n1_exp_d;
`ifdef FR_NORM_RNE_EN
  logic             n1_guard_q, n1_guard_d;
`endif

  // NOTE: each combinational output gets a default first so no path through the block infers a latch.
  always_comb begin
    n1_valid_d = dly_valid_q[ADDER_LAT-1];
    n1_sign_d  = sign_in;
    n1_mant_d  = sum_in;
    n1_exp_d   = sexp_t'({2'b00, dly_exp_q[ADDER_LAT-1]});
`ifdef FR_NORM_RNE_EN
    n1_guard_d = 1'b0;
`endif
    if (carry_in) begin
      n1_mant_d = {1'b1, sum_in[MAN_W-1:1]};
      n1_exp_d  = n1_exp_d + sexp_t'(1);
`ifdef FR_NORM_RNE_EN
      n1_guard_d = sum_in[0];
`endif
    end
  end

  // N2: leading-zero count.
  logic             n2_valid_q, n2_valid_d;
  logic             n2_sign_q, n2_sign_d;
  logic             n2_zero_q, n2_zero_d;
  logic [MAN_W-1:0] n2_mant_q, n2_mant_d;
  sexp_t            n2_exp_q, n2_exp_d;
  logic [LZW-1:0]   n2_lzc_q, n2_lzc_d;
`ifdef FR_NORM_RNE_EN
  logic             n2_guard_q, n2_guard_d;
`endif

  always_comb begin
    n2_valid_d = n1_valid_q;
    n2_sign_d  = n1_sign_q;
    n2_mant_d  = n1_mant_q;
    n2_exp_d   = n1_exp_q;
    n2_zero_d  = (n1_mant_q == '0);
`ifdef FR_NORM_RNE_EN
    n2_guard_d = n1_guard_q;
`endif
    // Ascending scan: the last hit is the most significant set bit.
    n2_lzc_d = LZW'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (n1_mant_q[i]) n2_lzc_d = LZW'(MAN_W - 1 - i);
    end
  end

  // N3: shift, exponent adjust, optional rounding, range checks and pack.
  logic [RW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  sexp_t            exp_fin;
  logic [MAN_W-2:0] frac_fin;
`ifdef FR_NORM_RNE_EN
  logic [MAN_W-1:0] mant_sh;
  logic [MAN_W:0]   mant_rnd;
`endif

  always_comb begin
`ifdef FR_NORM_RNE_EN
    mant_sh  = n2_mant_q << n2_lzc_q;
    // Guard is only set when lzc is 0 and sticky is always 0, so a set guard is an exact tie.
    mant_rnd = {1'b0, mant_sh} + (MAN_W+1)'(n2_guard_q & mant_sh[0]);
    frac_fin = (MAN_W-1)'(mant_rnd);
    exp_fin  = n2_exp_q - sexp_t'(n2_lzc_q) + sexp_t'(mant_rnd[MAN_W]);
`else
    frac_fin = (MAN_W-1)'(n2_mant_q << n2_lzc_q);
    exp_fin  = n2_exp_q - sexp_t'(n2_lzc_q);
`endif
    valid_d  = n2_valid_q;
    zero_d   = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    result_d = {n2_sign_q, exp_fin[EXP_W-1:0], frac_fin};
    if (n2_zero_q) begin
      result_d = '0;
      zero_d   = n2_valid_q;
    end else if (exp_fin < sexp_t'(1)) begin
      result_d = '0;
      unf_d    = n2_valid_q;
    end else if (exp_fin >= EXP_MAX) begin
      result_d = {n2_sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      ovf_d    = n2_valid_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n1_valid_q <= 1'b0;
      n1_sign_q  <= 1'b0;
      n1_mant_q  <= '0;
      n1_exp_q   <= '0;
      n2_valid_q <= 1'b0;
      n2_sign_q  <= 1'b0;
      n2_zero_q  <= 1'b0;
      n2_mant_q  <= '0;
      n2_exp_q   <= '0;
      n2_lzc_q   <= '0;
`ifdef FR_NORM_RNE_EN
      n1_guard_q <= 1'b0;
      n2_guard_q <= 1'b0;
`endif
      result_q   <= '0;
      valid_q    <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      n1_valid_q <= n1_valid_d;
      n1_sign_q  <= n1_sign_d;
      n1_mant_q  <= n1_mant_d;
      n1_exp_q   <= n1_exp_d;
      n2_valid_q <= n2_valid_d;
      n2_sign_q  <= n2_sign_d;
      n2_zero_q  <= n2_zero_d;
      n2_mant_q  <= n2_mant_d;
      n2_exp_q   <= n2_exp_d;
      n2_lzc_q   <= n2_lzc_d;
`ifdef FR_NORM_RNE_EN
      n1_guard_q <= n1_guard_d;
      n2_guard_q <= n2_guard_d;
`endif
      result_q   <= result_d;
      valid_q    <= valid_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign result_out = result_q;
  assign valid_out  = valid_q;
  assign zero_out   = zero_q;
  assign ovf_out    = ovf_q;
  assign unf_out    = unf_q;

endmodule
